// File: rtl/intc_arbiter.sv
// intc_arbiter: merges NUM_SRC level interrupt requests into a single CPU
// request/acknowledge/end-of-service handshake. Only one source is in
// flight at any time.
// Optional feature macro: INTC_ROUND_ROBIN_EN. When it is defined,
// arbitration is round-robin from a rotating pointer. When it is undefined,
// arbitration is fixed priority with source 0 highest.
module intc_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_irq_i,
    output logic [NUM_SRC-1:0] src_iack_o,
    output logic [NUM_SRC-1:0] src_iend_o,
    output logic               cpu_irq_o,
    output logic [VEC_W-1:0]   cpu_vector_o,
    input  logic               cpu_iack_i,
    input  logic               cpu_iend_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   grant_q, grant_d;
    logic [NUM_SRC-1:0] grant_oh_s;

    // Lowest-index requester wins.
    function automatic logic [VEC_W-1:0] pick_fixed(input logic [NUM_SRC-1:0] req);
        logic [VEC_W-1:0] idx;
        idx = {VEC_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = VEC_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef INTC_ROUND_ROBIN_EN
    logic [VEC_W-1:0] ptr_q, ptr_d;

    // Rotate the request vector so that the pointer position becomes bit 0.
    // Then pick the lowest index and map it back. The search wraps from
    // NUM_SRC-1 to 0.
    function automatic logic [VEC_W-1:0] pick_rr(input logic [NUM_SRC-1:0] req,
                                                 input logic [VEC_W-1:0]   ptr);
        logic [NUM_SRC-1:0] rot;
        int                 sum;
        rot = (req >> ptr) | (req << (NUM_SRC - int'(ptr)));
        sum = int'(pick_fixed(rot)) + int'(ptr);
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end else begin
            sum = sum;
        end
        return VEC_W'(sum);
    endfunction

    // Rotating priority pointer. It advances only when a service completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= {VEC_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // One-hot image of the current grant, used for the per-source strobes.
    assign grant_oh_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_q;

    // State and grant registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= {VEC_W{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic and handshake outputs. The strobes follow the CPU
    // inputs within the same cycle. A withdrawal in REQ loses to a
    // simultaneous acknowledge.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
`ifdef INTC_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        cpu_irq_o    = 1'b0;
        cpu_vector_o = {VEC_W{1'b0}};
        src_iack_o   = {NUM_SRC{1'b0}};
        src_iend_o   = {NUM_SRC{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (|src_irq_i) begin
`ifdef INTC_ROUND_ROBIN_EN
                    grant_d = pick_rr(src_irq_i, ptr_q);
`else
                    grant_d = pick_fixed(src_irq_i);
`endif
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                cpu_irq_o    = 1'b1;
                cpu_vector_o = grant_q;
                if (cpu_iack_i) begin
                    src_iack_o = grant_oh_s;
                    state_d    = ST_SERVICE;
                end else if (!src_irq_i[grant_q]) begin
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_REQ;
                end
            end
            ST_SERVICE: begin
                cpu_vector_o = grant_q;
                if (cpu_iend_i) begin
                    src_iend_o = grant_oh_s;
                    state_d    = ST_IDLE;
`ifdef INTC_ROUND_ROBIN_EN
                    if (int'(grant_q) == NUM_SRC - 1) begin
                        ptr_d = {VEC_W{1'b0}};
                    end else begin
                        ptr_d = grant_q + {{(VEC_W-1){1'b0}}, 1'b1};
                    end
`endif
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intc_arbiter.sv
// Testbench for intc_arbiter.
// The stimulus pushes each expected event (IRQ rise with vector, IACK
// strobe, IEND strobe), together with the cycle in which it must appear,
// into a scoreboard. An independent monitor pops the queue and compares
// whenever the DUT presents one of these events.
module tb_intc_arbiter;

    localparam int NUM_SRC = 4;
    localparam int VEC_W   = 2;

    localparam int EV_IRQ  = 0;
    localparam int EV_IACK = 1;
    localparam int EV_IEND = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] src_irq;
    logic [NUM_SRC-1:0] src_iack;
    logic [NUM_SRC-1:0] src_iend;
    logic               cpu_irq;
    logic [VEC_W-1:0]   cpu_vector;
    logic               cpu_iack;
    logic               cpu_iend;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    ev_t exp_q[$];
    logic irq_prev = 1'b0;

    intc_arbiter #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_irq_i    (src_irq),
        .src_iack_o   (src_iack),
        .src_iend_o   (src_iend),
        .cpu_irq_o    (cpu_irq),
        .cpu_vector_o (cpu_vector),
        .cpu_iack_i   (cpu_iack),
        .cpu_iend_i   (cpu_iend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to timestamp events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input int kind, input int val);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, expected none", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: samples on the falling edge and scores every DUT event.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_irq && !irq_prev) mon_ev(EV_IRQ, int'(cpu_vector));
            if (src_iack != '0)       mon_ev(EV_IACK, int'(src_iack));
            if (src_iend != '0)       mon_ev(EV_IEND, int'(src_iend));
        end
        irq_prev = cpu_irq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A request must already be present and the DUT must be idle. The task
    // runs one full handshake and returns with the DUT idle again.
    task automatic txn(input int vec, input int iack_wait, input int iend_wait, input bit drop_on_ack);
        push(EV_IRQ, vec, cyc + 1);
        tick();
        repeat (iack_wait) tick();
        cpu_iack = 1'b1;
        if (drop_on_ack) src_irq = '0;
        push(EV_IACK, 1 << vec, cyc);
        tick();
        cpu_iack = 1'b0;
        repeat (iend_wait) tick();
        cpu_iend = 1'b1;
        push(EV_IEND, 1 << vec, cyc);
        tick();
        cpu_iend = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    int rr_exp[5];

    initial begin
        rst      = 1'b1;
        src_irq  = '0;
        cpu_iack = 1'b0;
        cpu_iend = 1'b0;
        tick();
        // Outputs are held at zero during reset, even with requests present.
        src_irq = 4'b1111;
        cpu_iend = 1'b1;
        #2;
        check("rst_cpu_irq", cpu_irq, 0);
        check("rst_vector", cpu_vector, 0);
        check("rst_iack", src_iack, 0);
        check("rst_iend", src_iend, 0);
        src_irq  = '0;
        cpu_iend = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single source 0.
        src_irq = 4'b0001;
        txn(0, 0, 0, 1'b1);
        tick();

        // Fixed-priority contention: source 1 goes first, then source 3 once source 1 drops.
        src_irq = 4'b1010;
        txn(1, 1, 2, 1'b0);
        src_irq = 4'b1000;
        txn(3, 0, 1, 1'b1);
        tick();

        // Withdrawal before the acknowledge, then a stray IEND while idle.
        src_irq = 4'b0100;
        push(EV_IRQ, 2, cyc + 1);
        tick();
        src_irq = 4'b0000;
        tick();
        check("withdraw_irq_low", cpu_irq, 0);
        cpu_iend = 1'b1;
        #1;
        check("stray_iend", src_iend, 0);
        tick();
        cpu_iend = 1'b0;
        cpu_iack = 1'b1;
        #1;
        check("stray_iack", src_iack, 0);
        tick();
        cpu_iack = 1'b0;
        tick();

        // An acknowledge and a withdrawal in the same cycle count as an acknowledge.
        src_irq = 4'b1000;
        push(EV_IRQ, 3, cyc + 1);
        tick();
        src_irq  = 4'b0000;
        cpu_iack = 1'b1;
        push(EV_IACK, 4'b1000, cyc);
        tick();
        cpu_iack = 1'b0;
        cpu_iend = 1'b1;
        push(EV_IEND, 4'b1000, cyc);
        tick();
        cpu_iend = 1'b0;
        tick();

        // While in service, new requests and a repeated IACK are ignored.
        src_irq = 4'b0100;
        push(EV_IRQ, 2, cyc + 1);
        tick();
        cpu_iack = 1'b1;
        push(EV_IACK, 4'b0100, cyc);
        tick();
        src_irq = 4'b0001;
        tick();
        check("service_vector_stable", cpu_vector, 2);
        check("service_irq_low", cpu_irq, 0);
        cpu_iack = 1'b0;
        cpu_iend = 1'b1;
        push(EV_IEND, 4'b0100, cyc);
        tick();
        cpu_iend = 1'b0;
        txn(0, 0, 0, 1'b1);
        tick();

        // Reset in the middle of a service, then a normal grant.
        src_irq = 4'b0001;
        push(EV_IRQ, 0, cyc + 1);
        tick();
        cpu_iack = 1'b1;
        push(EV_IACK, 4'b0001, cyc);
        tick();
        cpu_iack = 1'b0;
        cpu_iend = 1'b1;
        rst      = 1'b1;
        #1;
        check("midrst_irq", cpu_irq, 0);
        check("midrst_vector", cpu_vector, 0);
        check("midrst_iend", src_iend, 0);
        check("midrst_iack", src_iack, 0);
        tick();
        cpu_iend = 1'b0;
        rst      = 1'b0;
        txn(0, 0, 0, 1'b1);
        tick();

        // Five back-to-back transactions with every source requesting.
        do_reset();
`ifdef INTC_ROUND_ROBIN_EN
        rr_exp = '{0, 1, 2, 3, 0};
`else
        rr_exp = '{0, 0, 0, 0, 0};
`endif
        src_irq = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            txn(rr_exp[k], 0, 0, 1'b0);
        end
        src_irq = 4'b0000;
        tick();
        tick();

        // Periodic timer on bit 2. The CPU acknowledges 3 cycles and ends
        // service 10 cycles after CPU_IRQ rises.
        for (int p = 0; p < 3; p++) begin
            src_irq = 4'b0100;
            txn(2, 3, 6, 1'b1);
            repeat (5) tick();
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intc_arbiter.md
INTC_ARBITER -- requirements
Module: intc_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of interrupt sources (legal range 2..16).
REQ-002 Parameter VEC_W, default 2, SHALL set the vector width, with 2**VEC_W >= NUM_SRC.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 SRC_IRQ  input  NUM_SRC  SHALL carry the level interrupt requests; bit i is source i.
REQ-006 SRC_IACK  output  NUM_SRC  SHALL be the per-source acknowledge strobe.
REQ-007 SRC_IEND  output  NUM_SRC  SHALL be the per-source end-of-service strobe.
REQ-008 CPU_IRQ  output  1  SHALL be the merged interrupt request to the CPU.
REQ-009 CPU_VECTOR  output  VEC_W  SHALL be the index of the granted source.
REQ-010 CPU_IACK  input  1  SHALL be the CPU acknowledge.
REQ-011 CPU_IEND  input  1  SHALL be the CPU end-of-service.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-013 IDLE: when any SRC_IRQ bit is high, the block SHALL register the winning index into grant and go to REQ; otherwise it SHALL stay in IDLE.
REQ-014 Grant latency SHALL be one cycle: CPU_IRQ rises in the cycle after a request is sampled in IDLE.
REQ-015 In REQ, CPU_IRQ SHALL be 1; in all other states it SHALL be 0.
REQ-016 In REQ and SERVICE, CPU_VECTOR SHALL equal grant and SHALL be stable; in IDLE it SHALL be 0.
REQ-017 REQ with CPU_IACK=1: SRC_IACK[grant] SHALL be high combinationally in that cycle; the next state SHALL be SERVICE.
REQ-018 REQ with CPU_IACK=0 and SRC_IRQ[grant]=0 (withdrawn): the block SHALL return to IDLE without any SRC_IACK.
REQ-019 Simultaneous CPU_IACK and withdrawal SHALL be treated as an acknowledge (REQ-017 wins).
REQ-020 SERVICE with CPU_IEND=1: SRC_IEND[grant] SHALL be high combinationally in that cycle; the next state SHALL be IDLE.
REQ-021 SERVICE with CPU_IEND=0: the block SHALL stay in SERVICE indefinitely, ignoring CPU_IACK and all SRC_IRQ changes.
REQ-022 CPU_IACK outside REQ and CPU_IEND outside SERVICE SHALL be ignored.
REQ-023 At most one bit of SRC_IACK and SRC_IEND SHALL be high in any cycle, and only the bit at index grant.
REQ-024 Default arbitration SHALL be fixed priority, with source 0 highest and source NUM_SRC-1 lowest.
REQ-025 Requests arriving during REQ or SERVICE SHALL NOT change grant; they are arbitrated on the next IDLE cycle.
REQ-026 The back-to-back rate SHALL be one IDLE cycle between an IEND and the next REQ.

Reset
REQ-027 On RESET, state SHALL go to IDLE, and grant and the round-robin pointer SHALL go to 0.
REQ-028 During and after RESET, CPU_IRQ, CPU_VECTOR, SRC_IACK and SRC_IEND SHALL be 0.
REQ-029 RESET in REQ or SERVICE SHALL abandon the transaction with no SRC_IACK or SRC_IEND pulse.

Configuration
REQ-030 Macro INTC_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin.
  - The search starts at the pointer and wraps from NUM_SRC-1 to 0.
  - In each SERVICE->IDLE transition, the pointer SHALL load (grant+1) mod NUM_SRC.
  - The pointer SHALL be unchanged by a withdrawal.
REQ-031 Macro INTC_ROUND_ROBIN_EN undefined: the pointer register SHALL NOT exist and fixed priority (REQ-024) SHALL apply.

Verification
REQ-032 Single source: SRC_IRQ=0001 -> CPU_IRQ=1 and CPU_VECTOR=0 in the next cycle; CPU_IACK -> SRC_IACK=0001 in the same cycle; CPU_IEND -> SRC_IEND=0001, then IDLE.
REQ-033 Contention in fixed priority: SRC_IRQ=1010 held -> CPU_VECTOR=1 first; after IEND with source 1 dropped -> CPU_VECTOR=3.
REQ-034 Round robin (INTC_ROUND_ROBIN_EN): SRC_IRQ=1111 held through 5 full transactions -> vectors 0,1,2,3,0.
REQ-035 Withdrawal: SRC_IRQ=0100 dropped while in REQ, before CPU_IACK -> CPU_IRQ=0 the next cycle and no SRC_IACK pulse; a stray CPU_IEND in IDLE -> SRC_IEND stays 0.
REQ-036 Reset mid-service: RESET asserted in SERVICE -> all outputs 0 immediately; after release with SRC_IRQ=0001 -> a normal grant of vector 0.
REQ-037 Periodic timer source on bit 2, with a CPU model issuing IACK 3 cycles and IEND 10 cycles after CPU_IRQ -> each timer period gives exactly one IACK pulse and one IEND pulse on bit 2.
